// File: rtl/spi_pkg.sv
// Shared SPI link definitions for transmitter_spi, receiver_spi and their benches.
package spi_pkg;

    localparam int unsigned SPI_WIDTH   = 32;
    localparam int unsigned SPI_CLK_DIV = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } spi_state_t;

    // Counter width able to hold values 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : spi_pkg

// File: rtl/spi_tick_gen.sv
// Divider producing a one-cycle tick every CLK_DIV enabled cycles.
// 'en' is the enable for the coming cycle: the first tick appears CLK_DIV-1
// edges after the edge at which en is first sampled high, so the consumer
// acts exactly CLK_DIV cycles after enabling. en low clears the divider.
module spi_tick_gen
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = SPI_CLK_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int unsigned CW = cnt_width(CLK_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    // Count enabled cycles and flag the last one of each period.
    always_comb begin
        cnt_d  = '0;
        tick_d = 1'b0;
        if (en) begin
            if (cnt_q == CNT_LAST) begin
                tick_d = 1'b1;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Divider state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule : spi_tick_gen

// File: rtl/transmitter_spi.sv
// SPI mode-0 master: serialises one WIDTH-bit word MSB first per new_sig rising edge.
module transmitter_spi
    import spi_pkg::*;
#(
    parameter int unsigned WIDTH   = SPI_WIDTH,
    parameter int unsigned CLK_DIV = SPI_CLK_DIV
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             new_sig,
    input  logic [WIDTH-1:0] in_sig,
    output logic             busy,
    output logic             sig_sent,
    output logic             spi_sclk,
    output logic             spi_mosi,
    output logic             spi_cs_n
);

    localparam int unsigned BCW = cnt_width(WIDTH + 1);
    localparam logic [BCW-1:0] BIT_MAX = BCW'(WIDTH);

    spi_state_t       state_q, state_d;
    // Holds the bits still to be sent after the one currently on spi_mosi.
    logic [WIDTH-2:0] shreg_q, shreg_d;
    logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
    logic             sclk_q, sclk_d;
    logic             mosi_q, mosi_d;
    logic             cs_n_q, cs_n_d;
    logic             busy_q, busy_d;
    logic             sent_q, sent_d;
    logic             new_sig_q;
    logic             accept_c;
    logic             tick;
    logic             tick_en_c;

    // Rising edge of the request, honoured only while idle.
    assign accept_c  = new_sig & ~new_sig_q & (state_q == IDLE);
    assign tick_en_c = (state_d != IDLE);

    spi_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (tick_en_c),
        .tick  (tick)
    );

    // Frame sequencing: next state and next output values.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        cs_n_d    = cs_n_q;
        busy_d    = busy_q;
        sent_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (accept_c) begin
                    shreg_d   = in_sig[WIDTH-2:0];
                    mosi_d    = in_sig[WIDTH-1];
                    bit_cnt_d = '0;
                    cs_n_d    = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                if (tick) begin
                    sclk_d    = 1'b1;
                    bit_cnt_d = BCW'(1);
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (tick) begin
                    if (sclk_q) begin
                        // Falling edge: present the next bit.
                        sclk_d  = 1'b0;
                        mosi_d  = shreg_q[WIDTH-2];
                        shreg_d = shreg_q << 1;
                    end else if (bit_cnt_q == BIT_MAX) begin
                        // Last bit's low half-period done; clock stays low.
                        state_d = HOLD;
                    end else begin
                        sclk_d    = 1'b1;
                        bit_cnt_d = (bit_cnt_q == BIT_MAX) ? bit_cnt_q
                                                           : bit_cnt_q + BCW'(1);
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    cs_n_d  = 1'b1;
                    mosi_d  = 1'b0;
                    sent_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            busy_q    <= 1'b0;
            sent_q    <= 1'b0;
            new_sig_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            cs_n_q    <= cs_n_d;
            busy_q    <= busy_d;
            sent_q    <= sent_d;
            new_sig_q <= new_sig;
        end
    end

    assign busy     = busy_q;
    assign sig_sent = sent_q;
    assign spi_sclk = sclk_q;
    assign spi_mosi = mosi_q;
    assign spi_cs_n = cs_n_q;

endmodule : transmitter_spi
